// File: rtl/ppu_video_timing_pkg.sv
// Shared timing constants and total-length helpers for the PPU raster generator.
package ppu_timing_pkg;

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned CNT_MAX_TOTAL = 1 << CNT_W;

    localparam int unsigned DEF_DOT_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/ppu_video_timing_if.sv
// Video timing bundle: raster outputs plus the CPU-side vblank status/NMI handshake.
interface ppu_video_timing_if;
    import ppu_timing_pkg::*;

    logic             dot_ce;
    logic             hsync_n;
    logic             vsync_n;
    logic             de;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             frame_start;
    logic             line_start;
    logic             vblank_start;
    logic             vblank_flag;
    logic             status_rd;
    logic             nmi_en;
    logic             nmi;

    modport master (
        output dot_ce, hsync_n, vsync_n, de, pix_x, pix_y,
        output frame_start, line_start, vblank_start, vblank_flag, nmi,
        input  status_rd, nmi_en
    );

    modport slave (
        input  dot_ce, hsync_n, vsync_n, de, pix_x, pix_y,
        input  frame_start, line_start, vblank_start, vblank_flag, nmi,
        output status_rd, nmi_en
    );

endinterface

// File: rtl/ppu_video_timing_dot.sv
// Dot clock-enable divider: one-clk dot_ce pulse every DOT_DIV PPU clocks.
module ppu_dot_divider #(
    parameter int unsigned DOT_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_dot_ce
);

    localparam int unsigned DW = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DOT_DIV - 1);

    generate
        if (DOT_DIV < 1) begin : g_bad_div
            $error("ppu_dot_divider: DOT_DIV must be at least 1");
        end
    endgenerate

    logic [DW-1:0] r_div_cnt;
    logic          r_dot_ce;
    logic          w_wrap;

    assign w_wrap = (r_div_cnt == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_dot_ce  <= 1'b0;
        end else begin
            r_dot_ce  <= w_wrap;
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
        end
    end

    assign o_dot_ce = r_dot_ce;

endmodule

// File: rtl/ppu_video_timing.sv
// Raster timing generator: h/v counters, sync/de decodes, event pulses, vblank flag and NMI.
module ppu_video_timing
    import ppu_timing_pkg::*;
#(
    parameter int unsigned DOT_DIV  = DEF_DOT_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    ppu_video_timing_if.master  bus
);

    localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_BEG   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_BEG + V_SYNC;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    generate
        if (H_TOTAL > CNT_MAX_TOTAL) begin : g_bad_h
            $error("ppu_video_timing: H_TOTAL exceeds counter range");
        end
        if (V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_v
            $error("ppu_video_timing: V_TOTAL exceeds counter range");
        end
    endgenerate

    logic             w_dot_ce;
    logic             w_h_wrap;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_de;
    logic             r_hsync_n;
    logic             r_vsync_n;
    logic             r_frame_start;
    logic             r_line_start;
    logic             r_vblank_start;
    logic             r_vblank_flag;
    logic             r_nmi;

    ppu_dot_divider #(
        .DOT_DIV (DOT_DIV)
    ) u_dot_div (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .o_dot_ce (w_dot_ce)
    );

    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + 1'b1;
        w_v_nxt  = r_v_cnt;
        if (w_h_wrap) begin
            w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end
    end

    // Decodes and pulses are computed from the next counter values so that they
    // land on the same edge as pix_x/pix_y.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt        <= H_LAST;
            r_v_cnt        <= V_LAST;
            r_de           <= 1'b0;
            r_hsync_n      <= 1'b1;
            r_vsync_n      <= 1'b1;
            r_frame_start  <= 1'b0;
            r_line_start   <= 1'b0;
            r_vblank_start <= 1'b0;
            r_vblank_flag  <= 1'b0;
            r_nmi          <= 1'b0;
        end else begin
            r_frame_start  <= 1'b0;
            r_line_start   <= 1'b0;
            r_vblank_start <= 1'b0;
            if (w_dot_ce) begin
                r_h_cnt        <= w_h_nxt;
                r_v_cnt        <= w_v_nxt;
                r_de           <= (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
                r_hsync_n      <= !((32'(w_h_nxt) >= HS_BEG) && (32'(w_h_nxt) < HS_END));
                r_vsync_n      <= !((32'(w_v_nxt) >= VS_BEG) && (32'(w_v_nxt) < VS_END));
                r_line_start   <= (w_h_nxt == '0);
                r_frame_start  <= (w_h_nxt == '0) && (w_v_nxt == '0);
                r_vblank_start <= (w_h_nxt == '0) && (32'(w_v_nxt) == V_ACTIVE);
            end
            // Setting has priority over a coincident status read.
            if (r_vblank_start) begin
                r_vblank_flag <= 1'b1;
            end else if (r_frame_start || bus.status_rd) begin
                r_vblank_flag <= 1'b0;
            end
            r_nmi <= r_vblank_flag & bus.nmi_en;
        end
    end

    assign bus.dot_ce       = w_dot_ce;
    assign bus.hsync_n      = r_hsync_n;
    assign bus.vsync_n      = r_vsync_n;
    assign bus.de           = r_de;
    assign bus.pix_x        = r_h_cnt;
    assign bus.pix_y        = r_v_cnt;
    assign bus.frame_start  = r_frame_start;
    assign bus.line_start   = r_line_start;
    assign bus.vblank_start = r_vblank_start;
    assign bus.vblank_flag  = r_vblank_flag;
    assign bus.nmi          = r_nmi;

endmodule

// File: tb/tb_ppu_video_timing.sv
// Directed bench for ppu_video_timing: default geometry, a small geometry, and DOT_DIV=1/3.
module tb_ppu_video_timing;

    logic clk;
    logic rst_n;
    int unsigned n_vec;
    int unsigned n_err;

    ppu_video_timing_if if_def ();
    ppu_video_timing_if if_sm  ();
    ppu_video_timing_if if_d1  ();
    ppu_video_timing_if if_d3  ();

    ppu_video_timing u_def (.i_clk(clk), .i_rst_n(rst_n), .bus(if_def));

    // 16 dots x 12 lines, DOT_DIV=2: line = 32 clks, frame = 384 clks
    ppu_video_timing #(
        .DOT_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_sm (.i_clk(clk), .i_rst_n(rst_n), .bus(if_sm));

    ppu_video_timing #(.DOT_DIV(1)) u_d1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d1));
    ppu_video_timing #(.DOT_DIV(3)) u_d3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({if_def.dot_ce, if_def.hsync_n, if_def.vsync_n, if_def.de, if_def.frame_start,
             if_def.line_start, if_def.vblank_start, if_def.vblank_flag, if_def.nmi} !== 9'b011000000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 011000000",
                     {if_def.dot_ce, if_def.hsync_n, if_def.vsync_n, if_def.de, if_def.frame_start,
                      if_def.line_start, if_def.vblank_start, if_def.vblank_flag, if_def.nmi});
        end
        n_vec++;
        if (if_def.pix_x !== 10'd799) begin
            n_err++; $display("FAIL reset_pix_x: got %0d expected 799", if_def.pix_x);
        end
        n_vec++;
        if (if_def.pix_y !== 10'd524) begin
            n_err++; $display("FAIL reset_pix_y: got %0d expected 524", if_def.pix_y);
        end
        n_vec++;
        if (if_d1.dot_ce !== 1'b0) begin
            n_err++; $display("FAIL reset_d1_dot_ce: got %b expected 0", if_d1.dot_ce);
        end
    endtask

    task automatic test_release_and_dividers();
        apply_reset();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_vec++;
            if (if_def.dot_ce !== ((k % 2) == 0)) begin
                n_err++; $display("FAIL div2_dot_ce clk %0d: got %b expected %b", k, if_def.dot_ce, (k % 2) == 0);
            end
            n_vec++;
            if (if_d1.dot_ce !== 1'b1) begin
                n_err++; $display("FAIL div1_dot_ce clk %0d: got %b expected 1", k, if_d1.dot_ce);
            end
            n_vec++;
            if (if_d3.dot_ce !== ((k % 3) == 0)) begin
                n_err++; $display("FAIL div3_dot_ce clk %0d: got %b expected %b", k, if_d3.dot_ce, (k % 3) == 0);
            end
            if (k == 2) begin
                n_vec++;
                if (if_def.frame_start !== 1'b0 || if_def.pix_x !== 10'd799) begin
                    n_err++; $display("FAIL pre_frame clk 2: got fs=%b x=%0d expected fs=0 x=799",
                                      if_def.frame_start, if_def.pix_x);
                end
            end
            if (k == 3) begin
                n_vec++;
                if ({if_def.frame_start, if_def.line_start, if_def.de} !== 3'b111 ||
                    if_def.pix_x !== 10'd0 || if_def.pix_y !== 10'd0) begin
                    n_err++; $display("FAIL first_frame clk 3: got fs/ls/de=%b x=%0d y=%0d expected 111 x=0 y=0",
                                      {if_def.frame_start, if_def.line_start, if_def.de}, if_def.pix_x, if_def.pix_y);
                end
            end
        end
    endtask

    task automatic test_horizontal();
        int unsigned hs_cnt, hs_first, hs_last, ls_cnt, de_fall, de_fall_x;
        int unsigned ls_t[3];
        logic prev_de;
        hs_cnt = 0; hs_first = 0; hs_last = 0; ls_cnt = 0; de_fall = 0; de_fall_x = 0;
        ls_t = '{0, 0, 0};
        prev_de = 1'b0;
        apply_reset();
        for (int k = 1; k <= 3300; k++) begin
            @(negedge clk);
            if (k < 1603 && if_def.hsync_n === 1'b0) begin
                if (hs_cnt == 0) hs_first = if_def.pix_x;
                hs_last = if_def.pix_x;
                hs_cnt++;
            end
            if (if_def.line_start === 1'b1) begin
                if (ls_cnt < 3) ls_t[ls_cnt] = k;
                ls_cnt++;
            end
            if (prev_de === 1'b1 && if_def.de === 1'b0 && de_fall == 0) begin
                de_fall   = k;
                de_fall_x = if_def.pix_x;
            end
            prev_de = if_def.de;
        end
        n_vec++;
        if (hs_cnt != 192) begin n_err++; $display("FAIL hsync_width: got %0d clks expected 192", hs_cnt); end
        n_vec++;
        if (hs_first != 656) begin n_err++; $display("FAIL hsync_first_x: got %0d expected 656", hs_first); end
        n_vec++;
        if (hs_last != 751) begin n_err++; $display("FAIL hsync_last_x: got %0d expected 751", hs_last); end
        n_vec++;
        if (ls_cnt != 3) begin n_err++; $display("FAIL line_start_count: got %0d expected 3", ls_cnt); end
        n_vec++;
        if (ls_t[0] != 3) begin n_err++; $display("FAIL line_start_first: got clk %0d expected 3", ls_t[0]); end
        n_vec++;
        if (ls_t[1] - ls_t[0] != 1600) begin n_err++; $display("FAIL line_period_0: got %0d expected 1600", ls_t[1] - ls_t[0]); end
        n_vec++;
        if (ls_t[2] - ls_t[1] != 1600) begin n_err++; $display("FAIL line_period_1: got %0d expected 1600", ls_t[2] - ls_t[1]); end
        n_vec++;
        if (de_fall != 1283 || de_fall_x != 640) begin
            n_err++; $display("FAIL de_fall: got clk %0d x=%0d expected clk 1283 x=640", de_fall, de_fall_x);
        end
    endtask

    task automatic test_vertical();
        int unsigned fs_cnt, vb_t, vb_x, vb_y, vs_cnt, vs_first, vs_last;
        int unsigned fl_rise, fl_fall, nmi_rise, nmi_fall;
        int unsigned fs_t[3];
        logic prev_fl, prev_nmi;
        fs_cnt = 0; vb_t = 0; vb_x = 99; vb_y = 99; vs_cnt = 0; vs_first = 0; vs_last = 0;
        fl_rise = 0; fl_fall = 0; nmi_rise = 0; nmi_fall = 0;
        fs_t = '{0, 0, 0};
        prev_fl = 1'b0; prev_nmi = 1'b0;
        if_sm.status_rd = 1'b0;
        if_sm.nmi_en    = 1'b1;
        apply_reset();
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (if_sm.frame_start === 1'b1) begin
                if (fs_cnt < 3) fs_t[fs_cnt] = k;
                fs_cnt++;
            end
            if (if_sm.vblank_start === 1'b1 && vb_t == 0) begin
                vb_t = k; vb_x = if_sm.pix_x; vb_y = if_sm.pix_y;
            end
            if (k < 387 && if_sm.vsync_n === 1'b0) begin
                if (vs_cnt == 0) vs_first = if_sm.pix_y;
                vs_last = if_sm.pix_y;
                vs_cnt++;
            end
            if (!prev_fl && if_sm.vblank_flag === 1'b1 && fl_rise == 0) fl_rise = k;
            if (prev_fl && if_sm.vblank_flag === 1'b0 && fl_fall == 0) fl_fall = k;
            if (!prev_nmi && if_sm.nmi === 1'b1 && nmi_rise == 0) nmi_rise = k;
            if (prev_nmi && if_sm.nmi === 1'b0 && nmi_fall == 0) nmi_fall = k;
            prev_fl  = if_sm.vblank_flag;
            prev_nmi = if_sm.nmi;
        end
        n_vec++;
        if (fs_cnt != 3 || fs_t[0] != 3 || fs_t[1] != 387 || fs_t[2] != 771) begin
            n_err++; $display("FAIL frame_period: got n=%0d at %0d,%0d,%0d expected n=3 at 3,387,771",
                              fs_cnt, fs_t[0], fs_t[1], fs_t[2]);
        end
        n_vec++;
        if (vb_t != 195 || vb_x != 0 || vb_y != 6) begin
            n_err++; $display("FAIL vblank_start: got clk %0d (%0d,%0d) expected clk 195 (0,6)", vb_t, vb_x, vb_y);
        end
        n_vec++;
        if (vs_cnt != 64 || vs_first != 8 || vs_last != 9) begin
            n_err++; $display("FAIL vsync_lines: got %0d clks y=%0d..%0d expected 64 clks y=8..9", vs_cnt, vs_first, vs_last);
        end
        n_vec++;
        if (fl_rise != 196 || fl_fall != 388) begin
            n_err++; $display("FAIL flag_window: got rise %0d fall %0d expected 196 388", fl_rise, fl_fall);
        end
        n_vec++;
        if (nmi_rise != 197 || nmi_fall != 389) begin
            n_err++; $display("FAIL nmi_window: got rise %0d fall %0d expected 197 389", nmi_rise, nmi_fall);
        end
    endtask

    task automatic test_flag_handshake();
        if_sm.status_rd = 1'b0;
        if_sm.nmi_en    = 1'b0;
        apply_reset();
        for (int k = 1; k <= 772; k++) begin
            @(negedge clk);
            if_sm.status_rd = 1'b0;
            if (k == 200) begin
                n_vec++;
                if (if_sm.vblank_flag !== 1'b1) begin
                    n_err++; $display("FAIL flag_before_rd: got %b expected 1", if_sm.vblank_flag);
                end
                if_sm.status_rd = 1'b1;
            end
            if (k == 201) begin
                n_vec++;
                if (if_sm.vblank_flag !== 1'b0) begin
                    n_err++; $display("FAIL flag_after_rd: got %b expected 0", if_sm.vblank_flag);
                end
            end
            if (k == 579) begin
                n_vec++;
                if (if_sm.vblank_start !== 1'b1 || if_sm.vblank_flag !== 1'b0) begin
                    n_err++; $display("FAIL vblank_start_2: got vs=%b flag=%b expected vs=1 flag=0",
                                      if_sm.vblank_start, if_sm.vblank_flag);
                end
                if_sm.status_rd = 1'b1;
            end
            if (k == 580) begin
                n_vec++;
                if (if_sm.vblank_flag !== 1'b1) begin
                    n_err++; $display("FAIL set_beats_rd: got %b expected 1", if_sm.vblank_flag);
                end
            end
            if (k == 771) begin
                n_vec++;
                if (if_sm.frame_start !== 1'b1 || if_sm.vblank_flag !== 1'b1) begin
                    n_err++; $display("FAIL flag_held: got fs=%b flag=%b expected fs=1 flag=1",
                                      if_sm.frame_start, if_sm.vblank_flag);
                end
            end
            if (k == 772) begin
                n_vec++;
                if (if_sm.vblank_flag !== 1'b0) begin
                    n_err++; $display("FAIL flag_frame_clear: got %b expected 0", if_sm.vblank_flag);
                end
            end
        end
    endtask

    task automatic test_nmi();
        if_sm.status_rd = 1'b0;
        if_sm.nmi_en    = 1'b1;
        apply_reset();
        for (int k = 1; k <= 226; k++) begin
            @(negedge clk);
            if (k == 196) begin
                n_vec++;
                if (if_sm.vblank_flag !== 1'b1 || if_sm.nmi !== 1'b0) begin
                    n_err++; $display("FAIL nmi_lag: got flag=%b nmi=%b expected flag=1 nmi=0", if_sm.vblank_flag, if_sm.nmi);
                end
            end
            if (k == 197) begin
                n_vec++;
                if (if_sm.nmi !== 1'b1) begin n_err++; $display("FAIL nmi_rise: got %b expected 1", if_sm.nmi); end
            end
            if (k == 220) if_sm.nmi_en = 1'b0;
            if (k == 221) begin
                n_vec++;
                if (if_sm.nmi !== 1'b0) begin n_err++; $display("FAIL nmi_en_drop: got %b expected 0", if_sm.nmi); end
            end
            if (k == 225) if_sm.nmi_en = 1'b1;
            if (k == 226) begin
                n_vec++;
                if (if_sm.nmi !== 1'b1) begin n_err++; $display("FAIL nmi_en_raise: got %b expected 1", if_sm.nmi); end
            end
        end
    endtask

    task automatic test_async_reset();
        if_sm.status_rd = 1'b0;
        if_sm.nmi_en    = 1'b1;
        apply_reset();
        for (int k = 1; k <= 604; k++) begin
            @(negedge clk);
        end
        n_vec++;
        if (if_def.pix_x !== 10'd300 || if_def.dot_ce !== 1'b1 || if_def.de !== 1'b1 ||
            if_sm.vblank_flag !== 1'b1 || if_sm.nmi !== 1'b1) begin
            n_err++; $display("FAIL pre_async: got x=%0d ce=%b de=%b flag=%b nmi=%b expected x=300 ce=1 de=1 flag=1 nmi=1",
                              if_def.pix_x, if_def.dot_ce, if_def.de, if_sm.vblank_flag, if_sm.nmi);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if_def.dot_ce, if_def.hsync_n, if_def.vsync_n, if_def.de, if_def.frame_start,
             if_def.line_start, if_def.vblank_start} !== 7'b0110000) begin
            n_err++; $display("FAIL async_ctrl: got %b expected 0110000",
                              {if_def.dot_ce, if_def.hsync_n, if_def.vsync_n, if_def.de, if_def.frame_start,
                               if_def.line_start, if_def.vblank_start});
        end
        n_vec++;
        if (if_def.pix_x !== 10'd799 || if_def.pix_y !== 10'd524) begin
            n_err++; $display("FAIL async_pix: got (%0d,%0d) expected (799,524)", if_def.pix_x, if_def.pix_y);
        end
        n_vec++;
        if (if_sm.vblank_flag !== 1'b0 || if_sm.nmi !== 1'b0) begin
            n_err++; $display("FAIL async_flag_nmi: got flag=%b nmi=%b expected 0 0", if_sm.vblank_flag, if_sm.nmi);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_def.status_rd = 1'b0; if_def.nmi_en = 1'b0;
        if_sm.status_rd  = 1'b0; if_sm.nmi_en  = 1'b0;
        if_d1.status_rd  = 1'b0; if_d1.nmi_en  = 1'b0;
        if_d3.status_rd  = 1'b0; if_d3.nmi_en  = 1'b0;

        test_reset();
        test_release_and_dividers();
        test_horizontal();
        test_vertical();
        test_flag_handshake();
        test_nmi();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
